// File: rtl/wb_rr_arbiter_if.sv
// wb_rr_if: Wishbone signals between N masters, the round-robin arbiter and one shared slave.
// The arbiter connects through the slave modport and the masters' side through the master modport.
interface wb_rr_if #(
    parameter int N_MASTERS = 2,
    parameter int ADR_WID   = 32,
    parameter int DAT_WID   = 32
);
    logic [N_MASTERS-1:0]           m_cyc, m_we, m_ack, m_err, grant;
    logic [N_MASTERS*ADR_WID-1:0]   m_adr;
    logic [N_MASTERS*DAT_WID-1:0]   m_dat_w;
    logic [N_MASTERS*DAT_WID/8-1:0] m_sel;
    logic [DAT_WID-1:0]             m_dat_r, s_dat_w, s_dat_r;
    logic [ADR_WID-1:0]             s_adr;
    logic [DAT_WID/8-1:0]           s_sel;
    logic                           s_cyc, s_stb, s_we, s_ack;
    modport slave (
        input  m_cyc, m_we, m_adr, m_dat_w, m_sel, s_dat_r, s_ack,
        output m_ack, m_err, m_dat_r, s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel, grant
    );
    modport master (
        output m_cyc, m_we, m_adr, m_dat_w, m_sel, s_dat_r, s_ack,
        input  m_ack, m_err, m_dat_r, s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel, grant
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone arbiter sharing one slave between N masters,
// holding grant for a whole CYC and ending hung transfers with ERR via a watchdog.
module wb_rr_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int ADR_WID        = 32,
    parameter int DAT_WID        = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WID    = 16
) (
    input logic    clk,
    input logic    rst,
    wb_rr_if.slave bus_io
);
    localparam int IW = $clog2(N_MASTERS);
    localparam int SW = DAT_WID / 8;
    typedef enum logic [1:0] {IDLE, GRANTED, ABORT} state_t;
    state_t                 state_q;
    logic [N_MASTERS-1:0]   grant_q;
    logic [IW-1:0]          idx_q, last_q, win, cand;
    logic [TIMEOUT_WID-1:0] wd_q, wd_d;
    logic                   own_cyc, expire;
    // Scan downwards so the nearest requester after last_q is the one left in win.
    always_comb begin
        win  = last_q;
        cand = '0;
        for (int k = N_MASTERS; k >= 1; k--) begin
            cand = IW'((int'(last_q) + k) % N_MASTERS);
            win  = bus_io.m_cyc[cand] ? cand : win;
        end
    end
    assign own_cyc = (state_q == GRANTED) && bus_io.m_cyc[idx_q];
    assign expire  = (TIMEOUT_CYCLES != 0) && own_cyc && !bus_io.s_ack
                     && (wd_q == TIMEOUT_WID'(TIMEOUT_CYCLES));
    assign wd_d    = ((TIMEOUT_CYCLES != 0) && own_cyc && !bus_io.s_ack && !expire)
                     ? ((&wd_q) ? wd_q : wd_q + TIMEOUT_WID'(1)) : '0;
    assign bus_io.s_cyc   = own_cyc && !expire;
    assign bus_io.s_stb   = bus_io.s_cyc;
    assign bus_io.s_we    = bus_io.m_we[idx_q];
    assign bus_io.s_adr   = bus_io.m_adr[idx_q*ADR_WID +: ADR_WID];
    assign bus_io.s_dat_w = bus_io.m_dat_w[idx_q*DAT_WID +: DAT_WID];
    assign bus_io.s_sel   = bus_io.m_sel[idx_q*SW +: SW];
    // An ACK only reaches the owner while its slave cycle is live; stray ACKs vanish.
    assign bus_io.m_ack   = (bus_io.s_cyc && bus_io.s_ack) ? grant_q : '0;
    assign bus_io.m_err   = expire ? grant_q : '0;
    assign bus_io.m_dat_r = bus_io.s_dat_r;
    assign bus_io.grant   = grant_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            last_q  <= IW'(N_MASTERS - 1);
            wd_q    <= '0;
        end else begin
            wd_q <= wd_d;
            if (state_q == IDLE) begin
                if (|bus_io.m_cyc) begin
                    state_q <= GRANTED;
                    idx_q   <= win;
                    grant_q <= N_MASTERS'(1) << win;
                end
            end else if (!bus_io.m_cyc[idx_q]) begin
                state_q <= IDLE;
                grant_q <= '0;
                last_q  <= idx_q;
            end else if (expire) begin
                state_q <= ABORT;
            end
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: scoreboard bench; masters run queued CYC sessions against a slave model,
// a round-robin session model predicts every ACK/ERR and a monitor checks them as they appear.
module tb_wb_rr_arbiter;
    localparam int N = 2, AW = 32, DW = 32, TO = 8, HANG = 99;
    localparam logic [31:0] K = 32'h5A5A_F00F;
    typedef struct {
        logic        we;
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        int          dly;
        bit          last;
    } beat_t;
    typedef struct {
        bit          err;
        int          m;
        logic        we;
        logic [31:0] adr, dat;
        logic [3:0]  sel;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_rr_if #(.N_MASTERS(N), .ADR_WID(AW), .DAT_WID(DW)) bus ();
    wb_rr_arbiter #(
        .N_MASTERS(N), .ADR_WID(AW), .DAT_WID(DW), .TIMEOUT_CYCLES(TO), .TIMEOUT_WID(16)
    ) dut (
        .clk(clk), .rst(rst), .bus_io(bus)
    );

    beat_t          mq [N][$];
    ev_t            sbq[$];
    int             dly_cur[N];
    logic [N-1:0]   ack_s, err_s;
    int             scnt, model_last, n_chk, n_pass;
    bit             stray;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic add_beat(input int i, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input int dly, input bit last);
        beat_t b;
        b.we = we; b.adr = adr; b.dat = dat; b.sel = sel; b.dly = dly; b.last = last;
        mq[i].push_back(b);
    endtask

    task automatic add_rand_session(input int i);
        int nb, d;
        nb = $urandom_range(1, 3);
        for (int j = 0; j < nb; j++) begin
            d = $urandom_range(0, 4);
            if ($urandom_range(0, 9) == 0) d = TO;
            if (j == nb - 1 && $urandom_range(0, 9) == 0) d = HANG;
            add_beat(i, 1'($urandom), $urandom, $urandom, 4'($urandom), d, j == nb - 1);
        end
    endtask

    // Whole sessions are served in rotation among masters that still have work.
    task automatic build_model();
        beat_t cp [N][$];
        beat_t b;
        ev_t   e;
        int    w;
        for (int i = 0; i < N; i++) cp[i] = mq[i];
        forever begin
            w = -1;
            for (int k = 1; k <= N; k++)
                if (w < 0 && cp[(model_last + k) % N].size() > 0) w = (model_last + k) % N;
            if (w < 0) break;
            do begin
                b = cp[w].pop_front();
                e.err = (b.dly == HANG); e.m = w; e.we = b.we;
                e.adr = b.adr; e.dat = b.dat; e.sel = b.sel;
                sbq.push_back(e);
            end while (!b.last);
            model_last = w;
        end
    endtask

    task automatic drive_head(input int i);
        beat_t b;
        b = mq[i][0];
        bus.m_we[i]              = b.we;
        bus.m_adr[i*AW +: AW]    = b.adr;
        bus.m_dat_w[i*DW +: DW]  = b.dat;
        bus.m_sel[i*4 +: 4]      = b.sel;
        dly_cur[i]               = b.dly;
    endtask

    // One clock: masters update after the edge, then the slave answers, then sample mid-cycle.
    task automatic step();
        beat_t b;
        int    gi;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            if (bus.m_cyc[i]) begin
                if ((ack_s[i] || err_s[i]) && mq[i].size() > 0) begin
                    b = mq[i].pop_front();
                    while (err_s[i] && !b.last && mq[i].size() > 0) b = mq[i].pop_front();
                    if (b.last || mq[i].size() == 0) bus.m_cyc[i] = 1'b0;
                    else drive_head(i);
                end
            end else if (mq[i].size() > 0) begin
                bus.m_cyc[i] = 1'b1;
                drive_head(i);
            end
        end
        #1;
        gi = 0;
        for (int i = 0; i < N; i++) if (bus.grant[i]) gi = i;
        bus.s_ack   = stray || (bus.grant != 0 && scnt == dly_cur[gi] && (bus.s_cyc || scnt != 0));
        bus.s_dat_r = bus.s_adr ^ K;
        @(negedge clk);
        ack_s = bus.m_ack;
        err_s = bus.m_err;
        scnt  = (bus.s_cyc && !bus.s_ack) ? scnt + 1 : 0;
    endtask

    task automatic run_phase(input string nm, input int budget);
        int n;
        n = 0;
        while ((mq[0].size() > 0 || mq[1].size() > 0 || bus.m_cyc != 0 || sbq.size() > 0) && n < budget) begin
            step();
            n++;
        end
        chk({nm, "_completes"}, n < budget, 1);
        repeat (2) step();
    endtask

    initial begin
        ev_t          e;
        logic [N-1:0] pg;
        int           run;
        pg  = '0;
        run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pg  = '0;
                run = 0;
            end else begin
                if (bus.grant != 0 && bus.grant != pg) chk("idle_cycle_before_new_grant", pg, 0);
                pg = bus.grant;
                if (|bus.m_ack || |bus.m_err) begin
                    if (sbq.size() == 0) chk("unexpected_ack_or_err", {bus.m_ack, bus.m_err}, 0);
                    else begin
                        e = sbq.pop_front();
                        if (e.err) begin
                            chk("err_owner", bus.m_err, 64'(1) << e.m);
                            chk("err_without_ack", bus.m_ack, 0);
                            chk("err_forces_s_cyc_low", bus.s_cyc, 0);
                            chk("err_after_timeout_cycles", run, TO);
                        end else begin
                            chk("ack_owner", bus.m_ack, 64'(1) << e.m);
                            chk("ack_grant", bus.grant, 64'(1) << e.m);
                            chk("ack_without_err", bus.m_err, 0);
                            chk("s_we", bus.s_we, e.we);
                            chk("s_adr", bus.s_adr, e.adr);
                            chk("s_dat_w", bus.s_dat_w, e.dat);
                            chk("s_sel", bus.s_sel, e.sel);
                            chk("m_dat_r", bus.m_dat_r, e.adr ^ K);
                        end
                    end
                end
                run = (bus.s_cyc && !bus.s_ack) ? run + 1 : 0;
            end
        end
    end

    initial begin
        int n;
        bus.m_cyc = '0; bus.m_we = '0; bus.m_adr = '0; bus.m_dat_w = '0; bus.m_sel = '0;
        bus.s_ack = 1'b0; bus.s_dat_r = '0;
        ack_s = '0; err_s = '0; scnt = 0; stray = 0; model_last = N - 1;
        n_chk = 0; n_pass = 0;
        dly_cur[0] = 0; dly_cur[1] = 0;
        repeat (2) @(negedge clk);
        chk("reset_grant", bus.grant, 0);
        chk("reset_s_cyc", bus.s_cyc, 0);
        chk("reset_m_ack", bus.m_ack, 0);
        chk("reset_m_err", bus.m_err, 0);
        rst = 1'b0;

        for (int s = 0; s < 3; s++) begin
            add_beat(0, 1'b1, 32'h0000_0100 + s, 32'hA000_0000 + s, 4'hF, 1, 1);
            add_beat(1, 1'b0, 32'h0000_0200 + s, 32'hB000_0000 + s, 4'h3, 2, 1);
        end
        build_model();
        run_phase("alternation", 200);

        add_beat(0, 1'b1, 32'h1000_000C, 32'h0010_0ABC, 4'hF, 3, 1);
        build_model();
        step();
        chk("s_cyc_low_in_request_cycle", bus.s_cyc, 0);
        step();
        chk("s_cyc_one_cycle_after_m_cyc", bus.s_cyc, 1);
        chk("single_master_s_adr", bus.s_adr, 32'h1000_000C);
        chk("single_master_s_dat_w", bus.s_dat_w, 32'h0010_0ABC);
        run_phase("single_write", 50);

        add_beat(0, 1'b1, 32'h0000_0010, 32'h1111_1111, 4'hF, 0, 1);
        add_beat(0, 1'b1, 32'h0000_0014, 32'h2222_2222, 4'hF, 1, 1);
        add_beat(1, 1'b1, 32'h2000_0000, 32'hDA7A_0001, 4'hF, 1, 0);
        add_beat(1, 1'b1, 32'h2000_0004, 32'h0000_0001, 4'h1, 0, 0);
        add_beat(1, 1'b1, 32'h2000_0004, 32'h0000_0000, 4'h1, 2, 1);
        build_model();
        run_phase("held_multibeat", 200);

        add_beat(0, 1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF, HANG, 1);
        add_beat(1, 1'b0, 32'h3000_0004, 32'h0, 4'hF, 1, 1);
        build_model();
        run_phase("watchdog_abort", 200);

        add_beat(1, 1'b0, 32'h4000_0000, 32'h0, 4'hF, TO, 1);
        build_model();
        run_phase("ack_beats_expiry", 100);

        stray = 1;
        step();
        chk("stray_ack_in_idle", bus.m_ack, 0);
        stray = 0;
        step();

        for (int s = 0; s < 40; s++) add_rand_session($urandom_range(0, 1));
        build_model();
        run_phase("random_sessions", 5000);

        add_beat(1, 1'b1, 32'h5000_0000, 32'h5555_5555, 4'hF, 6, 1);
        build_model();
        n = 0;
        while (!bus.s_cyc && n < 10) begin
            step();
            n++;
        end
        chk("reset_test_transfer_started", bus.s_cyc, 1);
        rst = 1'b1;
        #1;
        chk("async_reset_s_cyc", bus.s_cyc, 0);
        chk("async_reset_grant", bus.grant, 0);
        for (int i = 0; i < N; i++) mq[i].delete();
        sbq.delete();
        bus.m_cyc = '0; bus.s_ack = 1'b0;
        ack_s = '0; err_s = '0; scnt = 0; model_last = N - 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        add_beat(0, 1'b1, 32'h6000_0000, 32'h0000_0006, 4'hF, 1, 1);
        add_beat(1, 1'b1, 32'h6000_0004, 32'h0000_0007, 4'hF, 1, 1);
        build_model();
        run_phase("after_reset_master0_first", 100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
